adder_result_checker: RTL and testbench

ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

---
 rtl/adder_result_checker.sv | 194 +++++++++++++++++++
 tb/tb_adder_result_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// adder_result_checker: checks each accepted {carry,sum} against a+b+cin one edge after acceptance.
// Optional macro CHECK_STOP_ON_ERR_EN: a mismatch seen in RUN sends the FSM to HALT.
module adder_result_checker #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  input  logic [WIDTH-1:0]   sum,
  input  logic               carry,
  output logic [COUNT_W-1:0] pass_cnt,
  output logic [COUNT_W-1:0] fail_cnt,
  output logic               err_flag,
  output logic [WIDTH:0]     err_exp,
  output logic [WIDTH:0]     err_got,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic               cmp_vld_q, cmp_vld_d;
  logic [WIDTH-1:0]   cmp_a_q, cmp_a_d;
  logic [WIDTH-1:0]   cmp_b_q, cmp_b_d;
  logic [WIDTH-1:0]   cmp_sum_q, cmp_sum_d;
  logic               cmp_cin_q, cmp_cin_d;
  logic               cmp_carry_q, cmp_carry_d;

  logic [COUNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [COUNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic               err_flag_q, err_flag_d;
  logic [WIDTH:0]     err_exp_q, err_exp_d;
  logic [WIDTH:0]     err_got_q, err_got_d;

  logic               accept_s;
  logic               clear_s;
  logic               mismatch_s;
  logic [WIDTH:0]     exp_s;
  logic [WIDTH:0]     got_s;
  logic [COUNT_W-1:0] pass_base_s;
  logic [COUNT_W-1:0] fail_base_s;
  logic               err_base_s;
  logic [WIDTH:0]     exp_base_s;
  logic [WIDTH:0]     got_base_s;

  function automatic logic [WIDTH:0] full_sum(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt);
    if (cnt == {COUNT_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Handshake, compare-stage decode and start-clear qualification.
  always_comb begin
    accept_s   = in_valid && (state_q == ST_RUN);
    clear_s    = start && (state_q != ST_RUN);
    exp_s      = full_sum(cmp_a_q, cmp_b_q, cmp_cin_q);
    got_s      = {cmp_carry_q, cmp_sum_q};
    mismatch_s = cmp_vld_q && (exp_s != got_s);
  end

  // Next-state logic; start wins over stop outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (stop) state_d = ST_IDLE;
`ifdef CHECK_STOP_ON_ERR_EN
        else if (mismatch_s) state_d = ST_HALT;
`endif
        else state_d = ST_RUN;
      end
      ST_HALT: begin
        if (start)     state_d = ST_RUN;
        else if (stop) state_d = ST_IDLE;
        else           state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-entry compare stage loaded on every accepted transfer.
  always_comb begin
    cmp_vld_d   = accept_s;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    cmp_cin_d   = cmp_cin_q;
    cmp_sum_d   = cmp_sum_q;
    cmp_carry_d = cmp_carry_q;
    if (accept_s) begin
      cmp_a_d     = a;
      cmp_b_d     = b;
      cmp_cin_d   = cin;
      cmp_sum_d   = sum;
      cmp_carry_d = carry;
    end else begin
      cmp_vld_d   = 1'b0;
    end
  end

  // Result update: a start-clear applies first so a compare landing on the same edge still counts.
  always_comb begin
    pass_base_s = clear_s ? {COUNT_W{1'b0}} : pass_cnt_q;
    fail_base_s = clear_s ? {COUNT_W{1'b0}} : fail_cnt_q;
    err_base_s  = clear_s ? 1'b0 : err_flag_q;
    exp_base_s  = clear_s ? {(WIDTH+1){1'b0}} : err_exp_q;
    got_base_s  = clear_s ? {(WIDTH+1){1'b0}} : err_got_q;

    pass_cnt_d  = pass_base_s;
    fail_cnt_d  = fail_base_s;
    err_flag_d  = err_base_s;
    err_exp_d   = exp_base_s;
    err_got_d   = got_base_s;

    if (mismatch_s) begin
      fail_cnt_d = sat_inc(fail_base_s);
      err_flag_d = 1'b1;
      if (!err_base_s) begin
        err_exp_d = exp_s;
        err_got_d = got_s;
      end else begin
        err_exp_d = exp_base_s;
        err_got_d = got_base_s;
      end
    end else if (cmp_vld_q) begin
      pass_cnt_d = sat_inc(pass_base_s);
    end else begin
      pass_cnt_d = pass_base_s;
    end
  end

  // State, compare stage and results registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmp_vld_q   <= 1'b0;
      cmp_a_q     <= {WIDTH{1'b0}};
      cmp_b_q     <= {WIDTH{1'b0}};
      cmp_cin_q   <= 1'b0;
      cmp_sum_q   <= {WIDTH{1'b0}};
      cmp_carry_q <= 1'b0;
      pass_cnt_q  <= {COUNT_W{1'b0}};
      fail_cnt_q  <= {COUNT_W{1'b0}};
      err_flag_q  <= 1'b0;
      err_exp_q   <= {(WIDTH+1){1'b0}};
      err_got_q   <= {(WIDTH+1){1'b0}};
    end else begin
      state_q     <= state_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      cmp_cin_q   <= cmp_cin_d;
      cmp_sum_q   <= cmp_sum_d;
      cmp_carry_q <= cmp_carry_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      err_flag_q  <= err_flag_d;
      err_exp_q   <= err_exp_d;
      err_got_q   <= err_got_d;
    end
  end

  assign in_ready = (state_q == ST_RUN);
  assign busy     = (state_q != ST_IDLE) || cmp_vld_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign err_flag = err_flag_q;
  assign err_exp  = err_exp_q;
  assign err_got  = err_got_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Self-checking bench for adder_result_checker (WIDTH=8, COUNT_W=4) against a cycle-level behavioural model.
module tb_adder_result_checker;

  localparam int CMAX = 15;
`ifdef CHECK_STOP_ON_ERR_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic       clk, rst_n, start, stop, in_valid, in_ready;
  logic [7:0] a, b, sum;
  logic       cin, carry;
  logic [3:0] pass_cnt, fail_cnt;
  logic       err_flag, busy;
  logic [8:0] err_exp, err_got;

  int vectors = 0;
  int miscompares = 0;

  // Model: 0 idle, 1 run, 2 halt
  int m_st, m_pass, m_fail, m_exp, m_got, p_exp, p_got;
  bit m_err, m_pend;

  adder_result_checker #(.WIDTH(8), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sum(sum), .carry(carry),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_flag(err_flag),
    .err_exp(err_exp), .err_got(err_got), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_st = 0; m_pass = 0; m_fail = 0; m_exp = 0; m_got = 0;
    m_err = 1'b0; m_pend = 1'b0; p_exp = 0; p_got = 0;
  endtask

  // One clock: drive at negedge, advance the model at posedge, return at next negedge.
  task automatic cyc(input bit v, input bit st, input bit sp,
                     input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                     input logic [7:0] is, input logic ico);
    bit acc, mis;
    logic [8:0] g;
    in_valid = v; start = st; stop = sp;
    a = ia; b = ib; cin = ic; sum = is; carry = ico;
    @(posedge clk);
    acc = (m_st == 1) && v;
    if (st && m_st != 1) begin
      m_pass = 0; m_fail = 0; m_err = 1'b0; m_exp = 0; m_got = 0;
    end
    mis = m_pend && (p_exp != p_got);
    if (m_pend) begin
      if (!mis) begin
        if (m_pass < CMAX) m_pass++;
      end else begin
        if (m_fail < CMAX) m_fail++;
        if (!m_err) begin m_exp = p_exp; m_got = p_got; end
        m_err = 1'b1;
      end
    end
    case (m_st)
      0: if (st) m_st = 1;
      1: if (sp) m_st = 0; else if (HALT_EN && mis) m_st = 2;
      2: if (st) m_st = 1; else if (sp) m_st = 0;
      default: m_st = 0;
    endcase
    m_pend = acc;
    if (acc) begin
      p_exp = int'(ia) + int'(ib) + int'(ic);
      g = {ico, is};
      p_got = int'(g);
    end
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rnd_tx(input bit good, output logic [7:0] ia, output logic [7:0] ib,
                        output logic ic, output logic [7:0] is, output logic ico);
    logic [8:0] s;
    ia = 8'($urandom); ib = 8'($urandom); ic = 1'($urandom);
    s = {1'b0, ia} + {1'b0, ib} + {8'h00, ic};
    if (!good) s = s ^ (9'h001 << $urandom_range(0, 8));
    is = s[7:0]; ico = s[8];
  endtask

  task automatic test_reset();
    logic [7:0] ta, tb, ts; logic tc, tco;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0; sum = 8'h00; carry = 1'b0;
    model_reset();
    #12;
    vectors++;
    if ({in_ready, busy, err_flag, pass_cnt, fail_cnt, err_exp, err_got} !== 29'd0) begin
      $display("FAIL reset_init outputs got %h want 0",
               {in_ready, busy, err_flag, pass_cnt, fail_cnt, err_exp, err_got});
      miscompares++;
    end
    @(negedge clk); rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    rnd_tx(1'b1, ta, tb, tc, ts, tco);
    cyc(1'b1, 1'b0, 1'b0, ta, tb, tc, ts, tco);
    vectors++;
    if (busy !== 1'b1) begin $display("FAIL reset_pending busy got %b want 1", busy); miscompares++; end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, busy, err_flag, pass_cnt, fail_cnt, err_exp, err_got} !== 29'd0) begin
      $display("FAIL reset_midrun outputs got %h want 0",
               {in_ready, busy, err_flag, pass_cnt, fail_cnt, err_exp, err_got});
      miscompares++;
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    idle(); idle(); idle();
    vectors++;
    if (pass_cnt !== 4'd0) begin $display("FAIL reset_discard pass_cnt got %0d want 0", pass_cnt); miscompares++; end
  endtask

  task automatic test_pass();
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    vectors++;
    if (pass_cnt !== 4'd0) begin $display("FAIL pass_latency pass_cnt got %0d want 0", pass_cnt); miscompares++; end
    idle();
    vectors++;
    if (pass_cnt !== 4'd1 || err_flag !== 1'b0) begin
      $display("FAIL pass pass_cnt/err_flag got %0d/%b want 1/0", pass_cnt, err_flag); miscompares++;
    end
  endtask

  task automatic test_carry();
    cyc(1'b1, 1'b0, 1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1);
    idle();
    vectors++;
    if (pass_cnt !== 4'd2 || fail_cnt !== 4'd0) begin
      $display("FAIL carry pass/fail got %0d/%0d want 2/0", pass_cnt, fail_cnt); miscompares++;
    end
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_mismatch();
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h03, 8'h04, 1'b0, 8'h08, 1'b0);
    idle();
    cyc(1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 8'h05, 1'b0);
    idle(); idle();
    vectors++;
    if (err_flag !== 1'b1 || err_exp !== 9'h007 || err_got !== 9'h008) begin
      $display("FAIL mismatch flag/exp/got got %b/%h/%h want 1/007/008", err_flag, err_exp, err_got);
      miscompares++;
    end
    vectors++;
    if (fail_cnt !== (HALT_EN ? 4'd1 : 4'd2) || in_ready !== !HALT_EN) begin
      $display("FAIL mismatch fail_cnt/in_ready got %0d/%b want %0d/%b",
               fail_cnt, in_ready, HALT_EN ? 1 : 2, !HALT_EN);
      miscompares++;
    end
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    idle();
    vectors++;
    if (busy !== 1'b0 || err_exp !== 9'h007) begin
      $display("FAIL mismatch_stop busy/err_exp got %b/%h want 0/007", busy, err_exp); miscompares++;
    end
  endtask

  task automatic test_saturation();
    logic [7:0] ta, tb, ts; logic tc, tco;
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) begin
      rnd_tx(1'b1, ta, tb, tc, ts, tco);
      cyc(1'b1, 1'b0, 1'b0, ta, tb, tc, ts, tco);
    end
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    idle();
    vectors++;
    if (pass_cnt !== 4'hF || busy !== 1'b0 || fail_cnt !== 4'd0) begin
      $display("FAIL saturation pass/busy/fail got %h/%b/%h want F/0/0", pass_cnt, busy, fail_cnt);
      miscompares++;
    end
  endtask

  task automatic test_stop_boundary();
    logic [7:0] ta, tb, ts; logic tc, tco;
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    rnd_tx(1'b1, ta, tb, tc, ts, tco);
    cyc(1'b1, 1'b0, 1'b1, ta, tb, tc, ts, tco);
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL stop_edge in_ready/busy got %b/%b want 0/1", in_ready, busy); miscompares++;
    end
    idle();
    vectors++;
    if (pass_cnt !== 4'd1 || busy !== 1'b0) begin
      $display("FAIL stop_counted pass/busy got %0d/%b want 1/0", pass_cnt, busy); miscompares++;
    end
  endtask

  task automatic test_random();
    logic [7:0] ta, tb, ts; logic tc, tco;
    bit v, st, sp;
    for (int r = 0; r < 8; r++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 14; i++) begin
        v  = ($urandom_range(0, 3) != 0);
        st = ($urandom_range(0, 9) == 0);
        sp = ($urandom_range(0, 11) == 0);
        rnd_tx($urandom_range(0, 2) != 0, ta, tb, tc, ts, tco);
        cyc(v, st, sp, ta, tb, tc, ts, tco);
        vectors++;
        if (in_ready !== (m_st == 1) || busy !== (m_st != 0 || m_pend)) begin
          $display("FAIL random_hs r%0d c%0d in_ready/busy got %b/%b want %b/%b",
                   r, i, in_ready, busy, m_st == 1, m_st != 0 || m_pend);
          miscompares++;
        end
      end
      cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      idle();
      vectors++;
      if (pass_cnt !== 4'(m_pass) || fail_cnt !== 4'(m_fail) || err_flag !== m_err ||
          err_exp !== 9'(m_exp) || err_got !== 9'(m_got)) begin
        $display("FAIL random_res r%0d pass/fail/err/exp/got got %0d/%0d/%b/%h/%h want %0d/%0d/%b/%h/%h",
                 r, pass_cnt, fail_cnt, err_flag, err_exp, err_got,
                 m_pass, m_fail, m_err, m_exp, m_got);
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_carry();
    test_mismatch();
    test_saturation();
    test_stop_boundary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
